// File: rtl/operand_input_port.sv
// Operand entry peripheral: debounced ENTER/CANCEL sequence OPA, OPB, OPCODE
// Ports: clk/reset, SW/KEY_* raw inputs, a/we/wd bus in, rd/hit bus out, phase
module operand_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  SW,
  input  logic        KEY_ENTER,
  input  logic        KEY_CANCEL,
  input  logic [31:0] a,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic [1:0]  phase
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RDY = 2'd3
  } state_e;

  // index 0: enter, index 1: cancel
  logic [1:0]    key_raw;
  logic [1:0]    key_s1_q;
  logic [1:0]    key_s2_q;
  logic [1:0]    deb_q;
  logic [1:0]    deb_d;
  logic [1:0]    press;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  logic [9:0]    sw_s1_q;
  logic [9:0]    sw_s2_q;

  state_e        state_q;
  state_e        state_d;
  logic [9:0]    opa_q;
  logic [9:0]    opa_d;
  logic [9:0]    opb_q;
  logic [9:0]    opb_d;
  logic [2:0]    opc_q;
  logic [2:0]    opc_d;
  logic          valid_q;
  logic          valid_d;
  logic          ovr_q;
  logic          ovr_d;

  logic          enter_p;
  logic          cancel_p;
  logic [1:0]    off;
  logic          wr_stat;
  logic          clr_v;
  logic          clr_o;
  logic          unused_ok;

  assign key_raw   = {KEY_CANCEL, KEY_ENTER};
  assign unused_ok = ^{wd[31:2], a[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      key_s1_q <= key_raw;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Press fires on the cycle the debounced level is about to rise,
  // so the capture edge coincides with the level change.
  always_comb begin
    deb_d = deb_q;
    press = '0;
    for (int b = 0; b < 2; b++) begin
      cnt_d[b] = '0;
      if (key_s2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == TERM) begin
          deb_d[b] = key_s2_q[b];
          press[b] = key_s2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q <= '0;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  assign enter_p  = press[0];
  assign cancel_p = press[1];

  assign hit     = (a[31:4] == BASE_ADDR[31:4]);
  assign off     = a[3:2];
  assign wr_stat = we & hit & (off == 2'd0);
  assign clr_v   = wr_stat & wd[0];
  assign clr_o   = wr_stat & wd[1];

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opc_d   = opc_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_v) begin
      valid_d = 1'b0;
    end
    unique case (state_q)
      S_A: begin
        if (enter_p) begin
          opa_d   = sw_s2_q;
          state_d = S_B;
        end
      end
      S_B: begin
        if (cancel_p) begin
          state_d = S_A;
        end else if (enter_p) begin
          opb_d   = sw_s2_q;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (cancel_p) begin
          state_d = S_A;
        end else if (enter_p) begin
          opc_d   = sw_s2_q[2:0];
          valid_d = 1'b1;
          state_d = S_RDY;
        end
      end
      S_RDY: begin
        if (clr_v) begin
          state_d = S_A;
        end else if (enter_p) begin
          ovr_d = 1'b1;
        end
      end
    endcase
    // a CPU clear overrides a simultaneous overrun
    if (clr_o) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_A;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign phase = state_q;

  always_comb begin
    rd = '0;
    if (hit) begin
      unique case (off)
        2'd0: rd = {28'd0, state_q, ovr_q, valid_q};
        2'd1: rd = {22'd0, opa_q};
        2'd2: rd = {22'd0, opb_q};
        2'd3: rd = {29'd0, opc_q};
      endcase
    end
  end

endmodule

// File: doc/operand_input_port.md
# operand_input_port

Memory-mapped operand entry peripheral for the calculator ARM system. The user sets operand A, operand B and an opcode on the board switches and confirms each with a push-button. The block debounces the buttons, sequences the entry with a small FSM, and exposes the captured values as read-only data-bus registers. The ARM polls these registers and acknowledges consumption by writing the status register. It sits beside `dmem` on the same `a`/`we`/`wd` bus and carries user input into the processor; result display is the path in the opposite direction.

## Interface
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles a synchronized button needs before its debounced level changes (≥1)
- BASE_ADDR, 32'h0000_0080, word-aligned base of the 4-word register window

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- SW  in  10  raw switches (asynchronous)
- KEY_ENTER  in  1  raw enter button, active-high (asynchronous)
- KEY_CANCEL  in  1  raw cancel button, active-high (asynchronous)
- a  in  32  data-bus address (ALUResult)
- we  in  1  data-bus write enable (MemWrite)
- wd  in  32  data-bus write data
- rd  out  32  read data; combinational from `a`
- hit  out  1  `a` falls inside the window; combinational, selects `rd` over dmem
- phase  out  2  current FSM state, for LEDs

## Operation
- Input conditioning:
  - SW, KEY_ENTER and KEY_CANCEL each pass through a 2-FF synchronizer.
  - Each button then drives its own debouncer: a counter runs while the synchronized level differs from the debounced level. It clears when the two agree. When it reaches DEBOUNCE_CYCLES, the debounced level takes the new value.
  - A 0→1 transition of a debounced level produces a one-cycle press pulse.
- FSM states (`phase` encoding):
  - ENTER_A = 0: enter pulse captures synchronized SW into OPA (10 bits), then goes to ENTER_B.
  - ENTER_B = 1: enter pulse captures SW into OPB, then goes to ENTER_OP.
  - ENTER_OP = 2: enter pulse captures SW[2:0] into OPCODE, sets VALID, then goes to READY.
  - READY = 3: operands are held. An enter pulse sets OVERRUN and captures nothing.
  - Cancel pulse in ENTER_B or ENTER_OP returns to ENTER_A. OPA/OPB/OPCODE keep their old contents.
  - Cancel pulse in ENTER_A or READY is ignored.
- Register map (offset from BASE_ADDR; reads are zero-extended):
  - +0x0 STATUS: [0] VALID, [1] OVERRUN, [3:2] phase.
  - +0x4 OPA.
  - +0x8 OPB.
  - +0xC OPCODE.
- Address decode:
  - `hit` = (a[31:4] == BASE_ADDR[31:4]).
  - `a[1:0]` is ignored.
  - When `hit` = 0, `rd` = 0.
- Writes, when `we` and `hit`:
  - STATUS with wd[0]=1 clears VALID and returns READY→ENTER_A. With wd[0]=1 in any other state, only VALID is cleared.
  - STATUS with wd[1]=1 clears OVERRUN.
  - Writes to offsets +0x4..+0xC are ignored.
- Priorities when events land in the same cycle:
  - CPU clear write beats an enter pulse in READY: go to ENTER_A, do not set OVERRUN, capture nothing.
  - Cancel beats enter.
  - OVERRUN set and OVERRUN clear in the same cycle: the clear wins.

## Timing
- Reset values:
  - `phase` = 0; OPA, OPB, OPCODE, VALID and OVERRUN all 0.
  - Synchronizers, debounce counters and debounced levels all 0.
  - `rd` = 0 for any address outside the window.
- A button held through reset release produces one press after 2 + DEBOUNCE_CYCLES cycles.
- Latency from a raw button rising edge (stable afterwards) to the press pulse: 2 sync cycles + DEBOUNCE_CYCLES cycles.
- Register capture and state change happen at the clock edge on which the pulse is high. New values are readable on the next cycle.
- A bounce shorter than DEBOUNCE_CYCLES produces no pulse. A button held down produces exactly one pulse. Release then re-press is needed for the next pulse.
- Register reads are combinational, with zero-cycle latency, matching dmem.
- STATUS write effects are visible in the cycle after the write edge.
- Asserting reset mid-entry discards the partial entry and applies all reset values on that edge.

## Test plan
(DEBOUNCE_CYCLES=4)
- Full entry:
  - Stimulus: SW=10'd25 + enter, SW=10'd7 + enter, SW=3'd2 + enter.
  - Required: OPA reads 25, OPB reads 7, OPCODE reads 2, STATUS reads 0xD (VALID=1, phase=3).
  - Then CPU writes 1 to STATUS. Required: STATUS reads 0x0.
- Debounce:
  - Stimulus: KEY_ENTER toggles with high/low widths of 3 cycles for 30 cycles, then is held high.
  - Required: exactly one capture, exactly 6 cycles after the final rising edge.
- Overrun:
  - Stimulus: in READY, one enter press.
  - Required: STATUS=0xF; OPA/OPB/OPCODE unchanged.
  - Then CPU writes 2 to STATUS. Required: STATUS=0xD.
- Cancel:
  - Stimulus: in ENTER_OP, cancel press. Required: phase=0, OPA/OPB retained.
  - Stimulus: cancel and enter pulses in the same cycle in ENTER_B. Required: phase=0, OPB unchanged.
- Same-cycle clear and enter:
  - Stimulus: in READY, a STATUS write of 1 coincides with an enter pulse.
  - Required: phase=0, OVERRUN=0.
- Decode and reset:
  - Stimulus: a=BASE_ADDR+0x10. Required: hit=0, rd=0, and a write there has no effect.
  - Stimulus: reset asserted in ENTER_B. Required: every register reads 0 on the next cycle.
